exc_controller: RTL
===================

# exc_controller

Exception and interrupt sequencer for the five-stage MIPS pipeline. It evaluates the exception flags and PC delivered to the M stage by the E→M exception carrier, together with the six hardware interrupt lines. It decides whether the instruction in M traps, records SR/Cause/EPC, and drives the pipeline-wide flush, which connects to the carriers' `InterruptRequest`. It then redirects fetch to the handler, or back to EPC on ERET, through a valid/ack handshake.

## Interface
Parameters:
- `HANDLER_ADDR`, default 32'h0000_4180: exception vector.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `HWInt` in 6: level-sensitive hardware interrupt lines.
- `ErrorOvM` in 1: arithmetic overflow flag for the instruction in M.
- `ErrorRlM` in 1: reserved-instruction flag for the instruction in M.
- `PCM` in 32: PC of the instruction in M; 0 means bubble.
- `BDM` in 1: the instruction in M is in a branch delay slot.
- `EretM` in 1: the instruction in M is ERET.
- `CP0We` in 1: MTC0 write enable, from M.
- `CP0Addr` in 5: CP0 register number (12 = SR, 13 = Cause, 14 = EPC).
- `CP0Din` in 32: MTC0 write data.
- `CP0Dout` out 32: combinational MFC0 read of `CP0Addr`; unmapped addresses read 0.
- `FlushReq` out 1: kill all in-flight instructions; drives every carrier's `InterruptRequest`.
- `RedirectValid` out 1: fetch must load `RedirectPC`.
- `RedirectPC` out 32: new fetch address.
- `RedirectAck` in 1: fetch accepted the redirect.
- `EXL` out 1: exception level bit, exported for the hazard unit.

## Operation
CP0 registers:
- SR: IM[15:10], EXL[1], IE[0]; all other bits read 0.
- Cause: BD[31], IP[15:10], ExcCode[6:2]; all other bits read 0.
- EPC: full 32 bits.
- Cause.IP samples `HWInt` every cycle, regardless of state.

State machine: RUN → FLUSH → REDIRECT → RUN.

Trap evaluation (RUN only), in fixed priority order:
1. Interrupt: IE & !EXL & |(HWInt & IM); ExcCode 0.
2. `ErrorRlM`: ExcCode 10.
3. `ErrorOvM`: ExcCode 12.
4. Flags 2 and 3 are ignored when `PCM` = 0.
5. Synchronous exceptions are taken even when EXL = 1. They overwrite EPC and Cause; this is a deliberate simplification.

On a trap edge:
- EXL is set; ExcCode and BD are latched.
- EPC is loaded:
  - `BDM` = 1: EPC = PCM − 4.
  - `PCM` = 0 (interrupt taken on a bubble): EPC = LastPC + 4, where LastPC is an internal register holding the most recent nonzero `PCM` seen in RUN.
  - Otherwise: EPC = PCM.
- Target latched: `HANDLER_ADDR`.
- State → FLUSH.

ERET in RUN (no trap pending the same cycle, `PCM` ≠ 0):
- EXL is cleared.
- Target latched: EPC.
- State → FLUSH.
- A trap takes priority over ERET on the same cycle.

MTC0 writes:
- Applied only in RUN, and only when no trap or ERET fires that cycle.
- A write to Cause affects only writable fields (none in this design; IP/BD/ExcCode are hardware-owned), so it is ignored.
- Writes to SR (IM, EXL, IE) and EPC are applied.

FLUSH state: `FlushReq` = 1, `RedirectValid` = 1; the next state is always REDIRECT.

REDIRECT state:
- `FlushReq` = 1 and `RedirectValid` = 1 are held until `RedirectAck` = 1, then → RUN.
- `RedirectPC` stays constant while valid.

Reset values: state RUN; SR, Cause, EPC and LastPC = 0; `FlushReq` = 0, `RedirectValid` = 0, `RedirectPC` = 0, `EXL` = 0.

## Timing
- The trap decision is combinational on M inputs in cycle N and registered at the end of N.
- `FlushReq`/`RedirectValid` are first high in cycle N+1. Both are registered outputs decoded from state.
- Minimum redirect sequence is 2 cycles (FLUSH, then REDIRECT with `RedirectAck` already high).
- `RedirectAck` is sampled only in REDIRECT; an ack in FLUSH is ignored.
- No trap, ERET or CP0 write is accepted outside RUN; M inputs in those cycles belong to flushed instructions.
- Reset mid-sequence drops `FlushReq`/`RedirectValid` asynchronously. The FSM returns to RUN.
- `CP0Dout` reflects register contents before the current edge (read-before-write).

## Structure
- Shared package `exc_pkg`:
  - state encoding (RUN/FLUSH/REDIRECT);
  - CP0 register numbers 12/13/14;
  - ExcCode constants (INT = 0, RI = 10, OV = 12);
  - SR/Cause bit-position constants.
- One natural sub-module: `exc_cp0_regs` (SR/Cause/EPC/LastPC storage and read mux). The FSM and priority logic stay in `exc_controller`.

## Test plan
- Overflow at PCM = 0x3010, BDM = 0, RedirectAck tied 1 → EPC = 0x3010, ExcCode = 12, EXL = 1; FlushReq high exactly 2 cycles; RedirectPC = 0x4180.
- ErrorRlM and ErrorOvM together at PCM = 0x3020 with BDM = 1 → ExcCode = 10, BD = 1, EPC = 0x301C.
- SR = 0x0000_0401 (IM[10] = 1, IE = 1), HWInt[0] pulse while PCM = 0 and LastPC = 0x3040 → ExcCode = 0, EPC = 0x3044.
- Same interrupt with EXL = 1 → no flush. Then ERET at PCM = 0x4200 → EXL clears; RedirectPC = EPC; RedirectAck withheld 3 cycles → FlushReq/RedirectValid held 4 cycles total.
- MTC0 to EPC (0x5000) on the same cycle as an overflow at 0x3000 → EPC = 0x3000 (write dropped).
- Reset asserted in REDIRECT → FlushReq and RedirectValid fall within the same cycle, without waiting for a clock edge; SR/Cause/EPC read 0.

Source files
------------

// File: rtl/exc_pkg.sv
// rtl/exc_pkg.sv - shared encodings for the exception sequencer and its CP0 registers
package exc_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_REDIRECT = 2'd2
    } exc_state_e;

    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;

    localparam logic [4:0] EXC_INT = 5'd0;
    localparam logic [4:0] EXC_RI  = 5'd10;
    localparam logic [4:0] EXC_OV  = 5'd12;

    localparam int SR_IE_BIT    = 0;
    localparam int SR_EXL_BIT   = 1;
    localparam int IM_LSB       = 10;
    localparam int IM_MSB       = 15;
    localparam int CAUSE_BD_BIT = 31;
    localparam int EXC_LSB      = 2;
    localparam int EXC_MSB      = 6;

endpackage

// File: rtl/exc_cp0_regs.sv
// rtl/exc_cp0_regs.sv - SR/Cause/EPC/LastPC storage with combinational MFC0 read mux
module exc_cp0_regs
    import exc_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [5:0]  hw_int_i,
    input  logic        run_i,
    input  logic [31:0] pcm_i,
    input  logic        bdm_i,
    input  logic        trap_i,
    input  logic [4:0]  trap_code_i,
    input  logic        eret_i,
    input  logic        wr_en_i,
    input  logic [4:0]  addr_i,
    input  logic [31:0] wr_data_i,
    output logic [31:0] rd_data_o,
    output logic [5:0]  sr_im_o,
    output logic        sr_ie_o,
    output logic        sr_exl_o,
    output logic [31:0] epc_o
);

    logic [5:0]  im_q;
    logic        exl_q;
    logic        ie_q;
    logic [5:0]  ip_q;
    logic        bd_q;
    logic [4:0]  code_q;
    logic [31:0] epc_q;
    logic [31:0] last_pc_q;
    logic [31:0] epc_d;

    // A bubble has no PC of its own, so resume after the last real instruction.
    always_comb begin
        if (bdm_i) begin
            epc_d = pcm_i - 32'd4;
        end else if (pcm_i == 32'd0) begin
            epc_d = last_pc_q + 32'd4;
        end else begin
            epc_d = pcm_i;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            im_q      <= '0;
            exl_q     <= 1'b0;
            ie_q      <= 1'b0;
            ip_q      <= '0;
            bd_q      <= 1'b0;
            code_q    <= '0;
            epc_q     <= '0;
            last_pc_q <= '0;
        end else begin
            ip_q <= hw_int_i;
            if (run_i && (pcm_i != 32'd0)) begin
                last_pc_q <= pcm_i;
            end
            if (trap_i) begin
                exl_q  <= 1'b1;
                code_q <= trap_code_i;
                bd_q   <= bdm_i;
                epc_q  <= epc_d;
            end else if (eret_i) begin
                exl_q <= 1'b0;
            end else if (wr_en_i) begin
                if (addr_i == CP0_SR) begin
                    im_q  <= wr_data_i[IM_MSB:IM_LSB];
                    exl_q <= wr_data_i[SR_EXL_BIT];
                    ie_q  <= wr_data_i[SR_IE_BIT];
                end else if (addr_i == CP0_EPC) begin
                    epc_q <= wr_data_i;
                end
            end
        end
    end

    always_comb begin
        rd_data_o = '0;
        case (addr_i)
            CP0_SR: begin
                rd_data_o[IM_MSB:IM_LSB] = im_q;
                rd_data_o[SR_EXL_BIT]    = exl_q;
                rd_data_o[SR_IE_BIT]     = ie_q;
            end
            CP0_CAUSE: begin
                rd_data_o[CAUSE_BD_BIT]    = bd_q;
                rd_data_o[IM_MSB:IM_LSB]   = ip_q;
                rd_data_o[EXC_MSB:EXC_LSB] = code_q;
            end
            CP0_EPC: rd_data_o = epc_q;
            default: rd_data_o = '0;
        endcase
    end

    assign sr_im_o  = im_q;
    assign sr_ie_o  = ie_q;
    assign sr_exl_o = exl_q;
    assign epc_o    = epc_q;

endmodule

// File: rtl/exc_controller.sv
// rtl/exc_controller.sv - M-stage trap/ERET decision, pipeline flush and fetch redirect sequencer
module exc_controller
    import exc_pkg::*;
#(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  HWInt,
    input  logic        ErrorOvM,
    input  logic        ErrorRlM,
    input  logic [31:0] PCM,
    input  logic        BDM,
    input  logic        EretM,
    input  logic        CP0We,
    input  logic [4:0]  CP0Addr,
    input  logic [31:0] CP0Din,
    output logic [31:0] CP0Dout,
    output logic        FlushReq,
    output logic        RedirectValid,
    output logic [31:0] RedirectPC,
    input  logic        RedirectAck,
    output logic        EXL
);

    exc_state_e  state_q;
    logic        flush_q;
    logic        rvalid_q;
    logic [31:0] rpc_q;

    logic [5:0]  sr_im;
    logic        sr_ie;
    logic        sr_exl;
    logic [31:0] epc;

    logic        in_run;
    logic        pc_valid;
    logic        int_req;
    logic        trap;
    logic [4:0]  trap_code;
    logic        eret;
    logic        cp0_wr;

    assign in_run    = (state_q == ST_RUN);
    assign pc_valid  = (PCM != 32'd0);
    assign int_req   = sr_ie & ~sr_exl & (|(HWInt & sr_im));
    assign trap      = in_run & (int_req | (pc_valid & (ErrorRlM | ErrorOvM)));
    assign trap_code = int_req ? EXC_INT : (ErrorRlM ? EXC_RI : EXC_OV);
    assign eret      = in_run & ~trap & EretM & pc_valid;
    assign cp0_wr    = in_run & ~trap & ~eret & CP0We;

    exc_cp0_regs u_cp0 (
        .clk_i       (clk),
        .reset_i     (reset),
        .hw_int_i    (HWInt),
        .run_i       (in_run),
        .pcm_i       (PCM),
        .bdm_i       (BDM),
        .trap_i      (trap),
        .trap_code_i (trap_code),
        .eret_i      (eret),
        .wr_en_i     (cp0_wr),
        .addr_i      (CP0Addr),
        .wr_data_i   (CP0Din),
        .rd_data_o   (CP0Dout),
        .sr_im_o     (sr_im),
        .sr_ie_o     (sr_ie),
        .sr_exl_o    (sr_exl),
        .epc_o       (epc)
    );

    // The redirect target is latched on entry so it stays stable for the whole handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_RUN;
            flush_q  <= 1'b0;
            rvalid_q <= 1'b0;
            rpc_q    <= '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (trap || eret) begin
                        state_q  <= ST_FLUSH;
                        flush_q  <= 1'b1;
                        rvalid_q <= 1'b1;
                        rpc_q    <= trap ? HANDLER_ADDR : epc;
                    end
                end
                ST_FLUSH: begin
                    state_q <= ST_REDIRECT;
                end
                ST_REDIRECT: begin
                    if (RedirectAck) begin
                        state_q  <= ST_RUN;
                        flush_q  <= 1'b0;
                        rvalid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= ST_RUN;
                    flush_q  <= 1'b0;
                    rvalid_q <= 1'b0;
                end
            endcase
        end
    end

    assign FlushReq      = flush_q;
    assign RedirectValid = rvalid_q;
    assign RedirectPC    = rpc_q;
    assign EXL           = sr_exl;

endmodule
